// File: rtl/cr_structs.sv
// Shared TLV processor structures: the internal TLV bus word used by the
// TLVP blocks.
package cr_structs;

  localparam int TLVP_ORD_NUM_WIDTH = 10;

  typedef struct packed {
    logic                          insert;
    logic [7:0]                    typen;
    logic                          sot;
    logic                          eot;
    logic [3:0]                    tuser;
    logic [TLVP_ORD_NUM_WIDTH-1:0] ordern;
    logic [63:0]                   tdata;
  } tlvp_if_bus_t;

endpackage

// File: rtl/cr_tlvp_usr_arb_pkg.sv
// Types local to the user TLV arbiter. The state type is exported so that
// benches and debug logic can decode the arbiter FSM.
package cr_tlvp_usr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_XFER     = 2'd1,
    ST_ERR_HOLD = 2'd2
  } tlvp_usr_arb_state_e;

endpackage

// File: rtl/cr_tlvp_rr_pick.sv
// Rotating-priority encoder: returns the first asserted request at or after
// ptr, wrapping modulo N_REQ. Purely combinational; ptr must be < N_REQ.
module cr_tlvp_rr_pick #(
  parameter int N_REQ   = 4,
  parameter int N_REQ_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ_W-1:0] ptr,
  output logic               hit,
  output logic [N_REQ_W-1:0] idx
);

  localparam logic [N_REQ_W:0] N_EXT = (N_REQ_W+1)'(N_REQ);

  logic [N_REQ-1:0]              rot_req;
  logic [N_REQ-1:0][N_REQ_W-1:0] rot_idx;

  // Position gi of the rotated view holds source (ptr + gi) mod N_REQ; the
  // explicit subtract keeps the wrap correct for non power-of-two N_REQ.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    logic [N_REQ_W:0] sum_w;
    assign sum_w       = {1'b0, ptr} + (N_REQ_W+1)'(gi);
    assign rot_idx[gi] = (sum_w >= N_EXT) ? N_REQ_W'(sum_w - N_EXT) : N_REQ_W'(sum_w);
    assign rot_req[gi] = req[rot_idx[gi]];
  end

  // Lowest rotated position wins: scan downward so the last hit kept is the nearest.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        hit = 1'b1;
        idx = rot_idx[k];
      end
    end
  end

endmodule

// File: rtl/cr_tlvp_usr_arb.sv
// Round-robin arbiter sharing the single user outbound insertion port among
// N_REQ show-ahead TLV sources. A grant is held for a whole TLV (sot..eot),
// pops are qualified by the user FIFO almost-full/full, and the first word of
// each grant is framing-checked.
// Optional build macro: CR_TLVP_USR_ARB_PRIO0_EN gives source 0 strict
// priority at arbitration time (never pre-empting a TLV in flight).
module cr_tlvp_usr_arb
  import cr_structs::*;
  import cr_tlvp_usr_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int N_REQ_W = $clog2(N_REQ)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_REQ-1:0]                      req_empty,
  input  logic [N_REQ*$bits(tlvp_if_bus_t)-1:0] req_tlv,
  output logic [N_REQ-1:0]                      req_rd,
  input  logic                                  usr_ob_full,
  input  logic                                  usr_ob_afull,
  output logic                                  usr_ob_wr,
  output tlvp_if_bus_t                          usr_ob_tlv,
  output logic                                  arb_gnt_vld,
  output logic [N_REQ_W-1:0]                    arb_gnt_idx,
  output logic                                  arb_proto_err
);

  localparam int                 TW       = $bits(tlvp_if_bus_t);
  localparam logic [N_REQ_W-1:0] LAST_IDX = N_REQ_W'(N_REQ - 1);

  tlvp_usr_arb_state_e state_reg;
  logic [N_REQ_W-1:0]  gnt_idx_reg;
  logic [N_REQ_W-1:0]  rr_ptr_reg;
  logic                first_reg;
  logic                proto_err_reg;
  logic                usr_ob_wr_reg;
  tlvp_if_bus_t        usr_ob_tlv_reg;

  tlvp_if_bus_t        src_word [N_REQ];
  tlvp_if_bus_t        head_word;
  logic                pop;
  logic                pick_hit;
  logic [N_REQ_W-1:0]  pick_idx;
  logic                sel_hit;
  logic [N_REQ_W-1:0]  sel_idx;
  logic                adv_ptr;
  logic [N_REQ_W-1:0]  rr_ptr_next;

  // Unpack the per-source head words and decode the one-hot pop.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_src
    assign src_word[gi] = req_tlv[gi*TW +: TW];
    assign req_rd[gi]   = pop && (gnt_idx_reg == N_REQ_W'(gi));
  end

  assign head_word = src_word[gnt_idx_reg];

  // Afull covers the single word already registered toward the user FIFO.
  assign pop = (state_reg == ST_XFER) && !req_empty[gnt_idx_reg]
               && !usr_ob_afull && !usr_ob_full;

  cr_tlvp_rr_pick #(
    .N_REQ   (N_REQ),
    .N_REQ_W (N_REQ_W)
  ) u_pick (
    .req (~req_empty),
    .ptr (rr_ptr_reg),
    .hit (pick_hit),
    .idx (pick_idx)
  );

`ifdef CR_TLVP_USR_ARB_PRIO0_EN
  // Source 0 overrides the rotation and does not consume a rotation slot.
  assign sel_hit = pick_hit || !req_empty[0];
  assign sel_idx = !req_empty[0] ? '0 : pick_idx;
  assign adv_ptr = (gnt_idx_reg != '0);
`else
  assign sel_hit = pick_hit;
  assign sel_idx = pick_idx;
  assign adv_ptr = 1'b1;
`endif

  assign rr_ptr_next = (gnt_idx_reg == LAST_IDX) ? '0 : gnt_idx_reg + N_REQ_W'(1);

  // Arbitration FSM with registered write port, grant and framing state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      gnt_idx_reg    <= '0;
      rr_ptr_reg     <= '0;
      first_reg      <= 1'b0;
      proto_err_reg  <= 1'b0;
      usr_ob_wr_reg  <= 1'b0;
      usr_ob_tlv_reg <= '0;
    end else begin
      usr_ob_wr_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (sel_hit) begin
            gnt_idx_reg <= sel_idx;
            first_reg   <= 1'b1;
            state_reg   <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (pop) begin
            usr_ob_wr_reg  <= 1'b1;
            usr_ob_tlv_reg <= head_word;
            // First word must open a TLV, every later word must not.
            if (head_word.sot != first_reg) begin
              proto_err_reg <= 1'b1;
            end
            first_reg <= 1'b0;
            if (head_word.eot) begin
              if (adv_ptr) begin
                rr_ptr_reg <= rr_ptr_next;
              end
              state_reg <= ST_IDLE;
            end
          end
        end
        ST_ERR_HOLD: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_ERR_HOLD;
        end
      endcase
    end
  end

  assign usr_ob_wr     = usr_ob_wr_reg;
  assign usr_ob_tlv    = usr_ob_tlv_reg;
  assign arb_gnt_vld   = (state_reg == ST_XFER);
  assign arb_gnt_idx   = gnt_idx_reg;
  assign arb_proto_err = proto_err_reg;

endmodule

// File: tb/tb_cr_tlvp_usr_arb.sv
// Self-checking bench for cr_tlvp_usr_arb: queue-based source FIFOs and a
// TLV-level arbitration model predicting every output each cycle.
module tb_cr_tlvp_usr_arb;
  import cr_structs::*;
  import cr_tlvp_usr_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 2;
  localparam int TW = $bits(tlvp_if_bus_t);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [N-1:0]      req_empty;
  logic [N*TW-1:0]   req_tlv;
  logic [N-1:0]      req_rd;
  logic              usr_ob_full;
  logic              usr_ob_afull;
  logic              usr_ob_wr;
  tlvp_if_bus_t      usr_ob_tlv;
  logic              arb_gnt_vld;
  logic [W-1:0]      arb_gnt_idx;
  logic              arb_proto_err;

  cr_tlvp_usr_arb #(.N_REQ(N), .N_REQ_W(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_empty     (req_empty),
    .req_tlv       (req_tlv),
    .req_rd        (req_rd),
    .usr_ob_full   (usr_ob_full),
    .usr_ob_afull  (usr_ob_afull),
    .usr_ob_wr     (usr_ob_wr),
    .usr_ob_tlv    (usr_ob_tlv),
    .arb_gnt_vld   (arb_gnt_vld),
    .arb_gnt_idx   (arb_gnt_idx),
    .arb_proto_err (arb_proto_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Source FIFOs and bookkeeping
  tlvp_if_bus_t src_q [N][$];
  int           grant_log [$];
  int           wr_count;
  bit           prev_vld;

  // Reference model (TLV-level view of the arbiter)
  bit           m_busy;
  int           m_gnt;
  int           m_ptr;
  bit           m_first;
  bit           m_err;
  bit           m_wr;
  tlvp_if_bus_t m_tlv;
  bit           pop_pending;
  int           pop_src;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_empty[i] = (src_q[i].size() == 0);
      req_tlv[i*TW +: TW] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
    end
  endtask

  task automatic push_tlv(input int src, input int len, input bit bad_first);
    tlvp_if_bus_t w;
    for (int k = 0; k < len; k++) begin
      w.insert = 1'b1;
      w.typen  = 8'($urandom);
      w.sot    = (k == 0) && !bad_first;
      w.eot    = (k == len - 1);
      w.tuser  = 4'(src);
      w.ordern = TLVP_ORD_NUM_WIDTH'($urandom);
      w.tdata  = {$urandom, $urandom};
      src_q[src].push_back(w);
    end
    $display("push src=%0d len=%0d bad_first=%0d", src, len, bad_first);
  endtask

  // Next source to win arbitration, or -1 if none.
  function automatic int pick();
    int s;
`ifdef CR_TLVP_USR_ARB_PRIO0_EN
    if (!req_empty[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      s = (m_ptr + k) % N;
      if (!req_empty[s]) return s;
    end
    return -1;
  endfunction

  // One clock: check outputs mid-cycle, advance the model, apply pops after the edge.
  task automatic step();
    logic [N-1:0] exp_rd;
    tlvp_if_bus_t w;
    int s;
    @(negedge clk);
    if (usr_ob_wr) wr_count++;
    if (arb_gnt_vld && !prev_vld) begin
      grant_log.push_back(int'(arb_gnt_idx));
      $display("grant src=%0d at %0t", arb_gnt_idx, $time);
    end
    prev_vld = arb_gnt_vld;

    exp_rd = (m_busy && !req_empty[m_gnt] && !usr_ob_afull && !usr_ob_full)
             ? (N'(1) << m_gnt) : '0;
    chk("req_rd", 128'(req_rd), 128'(exp_rd));
    chk("wr", 128'(usr_ob_wr), 128'(m_wr));
    chk("tlv", 128'(usr_ob_tlv), 128'(m_tlv));
    chk("gnt_vld", 128'(arb_gnt_vld), 128'(m_busy));
    if (m_busy) chk("gnt_idx", 128'(arb_gnt_idx), 128'(m_gnt));
    chk("proto_err", 128'(arb_proto_err), 128'(m_err));

    m_wr = 1'b0;
    pop_pending = 1'b0;
    if (!m_busy) begin
      s = pick();
      if (s >= 0) begin
        m_busy  = 1'b1;
        m_gnt   = s;
        m_first = 1'b1;
      end
    end else if (exp_rd != '0) begin
      w = src_q[m_gnt][0];
      m_wr  = 1'b1;
      m_tlv = w;
      if (w.sot != m_first) m_err = 1'b1;
      m_first = 1'b0;
      pop_pending = 1'b1;
      pop_src = m_gnt;
      if (w.eot) begin
        m_busy = 1'b0;
`ifdef CR_TLVP_USR_ARB_PRIO0_EN
        if (m_gnt != 0) m_ptr = (m_gnt + 1) % N;
`else
        m_ptr = (m_gnt + 1) % N;
`endif
      end
    end

    @(posedge clk);
    #1;
    if (pop_pending) void'(src_q[pop_src].pop_front());
    pop_pending = 1'b0;
    drive_inputs();
  endtask

  task automatic clear_logs();
    grant_log.delete();
    wr_count = 0;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req_rd", 128'(req_rd), 128'(0));
    chk("rst_wr", 128'(usr_ob_wr), 128'(0));
    chk("rst_tlv", 128'(usr_ob_tlv), 128'(0));
    chk("rst_gnt_vld", 128'(arb_gnt_vld), 128'(0));
    chk("rst_gnt_idx", 128'(arb_gnt_idx), 128'(0));
    chk("rst_proto_err", 128'(arb_proto_err), 128'(0));
    for (int i = 0; i < N; i++) src_q[i].delete();
    m_busy = 1'b0; m_gnt = 0; m_ptr = 0; m_first = 1'b0; m_err = 1'b0;
    m_wr = 1'b0; m_tlv = '0; pop_pending = 1'b0; prev_vld = 1'b0;
    usr_ob_afull = 1'b0;
    usr_ob_full  = 1'b0;
    drive_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    $display("reset released at %0t", $time);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Run until every source is drained and no grant is held, within a budget.
  task automatic drain(input int budget, input string tag);
    int k = 0;
    bit done = 1'b0;
    while (!done && k < budget) begin
      step();
      k++;
      done = all_empty() && !m_busy;
    end
    chk(tag, 128'(done), 128'(1));
    step();
  endtask

  initial begin
    int cnt;
    usr_ob_afull = 1'b0;
    usr_ob_full  = 1'b0;
    req_empty    = '1;
    req_tlv      = '0;
    clear_logs();
    #2;
    do_reset();

    // Single TLV from source 2, then pointer check via a 0/3 contest
    push_tlv(2, 3, 1'b0);
    drive_inputs();
    drain(40, "t1_drain");
    chk("t1_ngnt", 128'(grant_log.size()), 128'(1));
    chk("t1_gnt", 128'(grant_log[0]), 128'(2));
    chk("t1_writes", 128'(wr_count), 128'(3));
    push_tlv(0, 1, 1'b0);
    push_tlv(3, 1, 1'b0);
    drive_inputs();
    drain(40, "t1b_drain");
    chk("t1_ptr_ngnt", 128'(grant_log.size()), 128'(3));
    chk("t1_ptr_first", 128'(grant_log[1]), 128'(3));
    chk("t1_ptr_second", 128'(grant_log[2]), 128'(0));

    // Fairness: every source holds two 2-word TLVs
    do_reset();
    for (int t = 0; t < 2; t++)
      for (int s = 0; s < N; s++) push_tlv(s, 2, 1'b0);
    drive_inputs();
    drain(200, "fair_drain");
    chk("fair_ngnt", 128'(grant_log.size()), 128'(8));
    for (int k = 0; k < 8; k++) chk($sformatf("fair_order%0d", k), 128'(grant_log[k]), 128'(k % N));
    chk("fair_writes", 128'(wr_count), 128'(16));

    // Backpressure: afull held for 5 cycles mid-TLV
    clear_logs();
    push_tlv(1, 4, 1'b0);
    drive_inputs();
    cnt = 0;
    while (wr_count < 2 && cnt < 20) begin step(); cnt++; end
    chk("bp_start", 128'(wr_count >= 2), 128'(1));
    usr_ob_afull = 1'b1;
    drive_inputs();
    repeat (5) step();
    chk("bp_hold_vld", 128'(arb_gnt_vld), 128'(1));
    chk("bp_hold_rd", 128'(req_rd), 128'(0));
    usr_ob_afull = 1'b0;
    drive_inputs();
    drain(40, "bp_drain");
    chk("bp_writes", 128'(wr_count), 128'(4));

    // Random traffic with random afull/full
    clear_logs();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int s = int'($urandom_range(0, N - 1));
        if (src_q[s].size() < 12) push_tlv(s, int'($urandom_range(1, 4)), 1'b0);
      end
      usr_ob_afull = ($urandom_range(0, 4) == 0);
      usr_ob_full  = ($urandom_range(0, 19) == 0);
      drive_inputs();
      step();
    end
    usr_ob_afull = 1'b0;
    usr_ob_full  = 1'b0;
    drive_inputs();
    drain(500, "rand_drain");

`ifdef CR_TLVP_USR_ARB_PRIO0_EN
    // Strict priority for source 0
    do_reset();
    for (int k = 0; k < 5; k++) push_tlv(0, 1, 1'b0);
    for (int k = 0; k < 3; k++) push_tlv(1, 1, 1'b0);
    drive_inputs();
    drain(100, "prio_drain");
    chk("prio_ngnt", 128'(grant_log.size()), 128'(8));
    for (int k = 0; k < 8; k++) chk($sformatf("prio_order%0d", k), 128'(grant_log[k]), 128'((k < 5) ? 0 : 1));
`endif

    // Framing error: first word of a grant lacks sot
    push_tlv(1, 2, 1'b1);
    drive_inputs();
    drain(40, "frm_drain");
    chk("frm_err", 128'(arb_proto_err), 128'(1));
    push_tlv(3, 2, 1'b0);
    drive_inputs();
    drain(40, "frm_drain2");
    chk("frm_sticky", 128'(arb_proto_err), 128'(1));

    // Reset in the middle of a 4-word TLV, then a clean TLV from source 0
    do_reset();
    push_tlv(0, 4, 1'b0);
    drive_inputs();
    cnt = 0;
    while (wr_count < 2 && cnt < 20) begin step(); cnt++; end
    chk("mid_start", 128'(wr_count >= 2), 128'(1));
    do_reset();
    push_tlv(0, 2, 1'b0);
    drive_inputs();
    drain(40, "post_rst_drain");
    chk("post_rst_ngnt", 128'(grant_log.size()), 128'(1));
    chk("post_rst_gnt", 128'(grant_log[0]), 128'(0));
    chk("post_rst_writes", 128'(wr_count), 128'(2));
    chk("post_rst_err", 128'(arb_proto_err), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cr_tlvp_usr_arb.md
# cr_tlvp_usr_arb

Round-robin arbiter that shares the TLV processor's single user outbound insertion port among `N_REQ` independent user TLV sources. It sits between the per-source show-ahead TLV FIFOs and the resequencer's user FIFO write port (`usr_ob_wr`/`usr_ob_tlv`/`usr_ob_full`/`usr_ob_afull`). It grants one source at a time, holds the grant for a whole TLV (sot through eot) so user TLVs are never interleaved, and honours the user FIFO's almost-full backpressure.

## Interface
- `N_REQ`, 4: number of requesting sources, 2..8.
- `N_REQ_W`, `$clog2(N_REQ)`: width of grant index.
- `clk` input 1: single clock. Reset is asynchronous and active-low.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_empty` input `N_REQ`: per-source FIFO empty, show-ahead.
- `req_tlv` input `N_REQ*$bits(tlvp_if_bus_t)`: per-source head word, with source i at slice i.
- `req_rd` output `N_REQ`: per-source pop, one-hot or zero. Combinational.
- `usr_ob_full` input 1: user FIFO full.
- `usr_ob_afull` input 1: user FIFO almost full.
- `usr_ob_wr` output 1: registered write strobe.
- `usr_ob_tlv` output `tlvp_if_bus_t`: registered write data.
- `arb_gnt_vld` output 1: a grant is held.
- `arb_gnt_idx` output `N_REQ_W`: index of the held grant.
- `arb_proto_err` output 1: sticky framing error.

## Operation
- FSM states are IDLE, XFER and ERR_HOLD. The encoding is free. Reset enters IDLE.
- IDLE:
  - Scan sources starting at `rr_ptr` upward, wrapping modulo `N_REQ`.
  - Select the first source with `~req_empty`.
  - On a hit, register `gnt_idx` and go to XFER. No pop occurs in IDLE.
- XFER:
  - `req_rd[gnt_idx] = ~req_empty[gnt_idx] & ~usr_ob_afull & ~usr_ob_full`.
  - Each pop forwards `req_tlv[gnt_idx]` to `usr_ob_tlv` on the next edge, with `usr_ob_wr`=1.
  - On a pop whose word has `eot`=1:
    - `rr_ptr <= (gnt_idx+1) mod N_REQ`. Wrap to 0 is explicit when `N_REQ` is not a power of two.
    - Go to IDLE.
  - Empty or backpressure inside a TLV keeps the grant with no pop. There is no timeout.
- Framing check, per granted stream:
  - The first popped word of a grant must have `sot`=1.
  - Later words must have `sot`=0.
  - A violation sets `arb_proto_err`, which is sticky until reset. The word is still forwarded.
  - A word with both `sot` and `eot` set is a legal single-word TLV.
- All other `req_rd` bits are 0 at all times.
- Non-pop cycles drive `usr_ob_wr`=0. `usr_ob_tlv` holds its last value.
- Simultaneous requests: rotation guarantees each non-empty source a grant within `N_REQ` TLVs.
- A source that goes empty while in IDLE is simply skipped.

## Timing
- Pop to `usr_ob_wr`: 1 cycle. Data is captured on the same edge.
- Arbitration costs 1 bubble cycle (the IDLE visit) per TLV. Sustained throughput for a TLV of L words is L/(L+1).
- The `usr_ob_afull` qualification covers the one registered word in flight. This requires the user FIFO afull threshold to be ≥1.
- Reset values: `req_rd`=0, `usr_ob_wr`=0, `usr_ob_tlv`=0, `arb_gnt_vld`=0, `arb_gnt_idx`=0, `arb_proto_err`=0, `rr_ptr`=0.
- Reset asserted mid-TLV:
  - All state clears immediately and asynchronously.
  - The partially sent TLV is not completed.
  - The sources are reset on the same `rst_n`.

## Configuration
- `CR_TLVP_USR_ARB_PRIO0_EN`
  - Defined: source 0 has strict priority. In IDLE, a non-empty source 0 wins regardless of `rr_ptr`. A grant to source 0 does not advance `rr_ptr`. An in-progress TLV is never pre-empted.
  - Undefined: pure round-robin as described above.
  - ERR_HOLD is unused in both modes and exists only for illegal-state recovery, returning to IDLE.

## Structure
- `tlvp_if_bus_t` and `TLVP_ORD_NUM_WIDTH` remain in the shared `cr_structs` package.
- Add `tlvp_usr_arb_state_e` to the package so the bench can decode the FSM.
- A natural sub-module is `cr_tlvp_rr_pick`:
  - Combinational rotate-priority encoder taking a request vector and pointer.
  - Returns a hit flag and an index.
  - Reusable by other TLVP arbiters.
- Total RTL is about 200 lines.

## Test plan
- Single TLV, no backpressure:
  - Stimulus: source 2 holds 3 words (sot, mid, eot), others empty.
  - Response: grant 2 one cycle after reset release plus 1; `usr_ob_wr` high 3 consecutive cycles; `rr_ptr`=3 afterwards.
- Fairness:
  - Stimulus: all 4 sources hold two 2-word TLVs each, `rr_ptr`=0.
  - Response: grant order 0,1,2,3,0,1,2,3; 16 writes; no interleaving within any TLV.
- Backpressure:
  - Stimulus: hold `usr_ob_afull`=1 for 5 cycles mid-TLV.
  - Response: `req_rd`=0 and `usr_ob_wr`=0 for those cycles; grant held; transfer resumes 1 cycle after afull drops; no word lost or duplicated.
- Framing error:
  - Stimulus: the granted first word has `sot`=0.
  - Response: `arb_proto_err`=1 on the next cycle and stays 1; the word is still written.
- Reset mid-TLV:
  - Stimulus: assert `rst_n`=0 after 2 of 4 words.
  - Response: all outputs 0 asynchronously; after release, a new TLV from source 0 is granted cleanly.
- `CR_TLVP_USR_ARB_PRIO0_EN` defined:
  - Stimulus: sources 0 and 1 continuously non-empty with 1-word TLVs.
  - Response: only source 0 is granted while it is non-empty; source 1 is granted only once source 0 is empty.
